// File: rtl/bus_master_68k_if.sv
// Bus and request/response signals for the 68000-style bus master.
// The master modport is the block's view; slave is the requester/responder side.
interface bus_master_68k_if;
  logic        REQ;
  logic        RW_REQ;
  logic [22:0] ADDR_IN;
  logic [1:0]  BYTE_SEL;
  logic [15:0] WDATA;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [15:0] RDATA;
  logic [22:0] ADDR_OUT;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic [15:0] DATA_IN;
  logic        AS;
  logic        UDS;
  logic        LDS;
  logic        RW;
  logic        DTACK;
  logic        BERR;

  modport master (
    input  REQ, RW_REQ, ADDR_IN, BYTE_SEL, WDATA, DATA_IN, DTACK, BERR,
    output BUSY, DONE, ERR, RDATA, ADDR_OUT, DATA_OUT, DATA_OE, AS, UDS, LDS, RW
  );

  modport slave (
    output REQ, RW_REQ, ADDR_IN, BYTE_SEL, WDATA, DATA_IN, DTACK, BERR,
    input  BUSY, DONE, ERR, RDATA, ADDR_OUT, DATA_OUT, DATA_OE, AS, UDS, LDS, RW
  );
endinterface

// File: rtl/bus_master_68k.sv
// 68000-style asynchronous bus master: one read or write per request, with
// synchronized DTACK/BERR, bus-error and timeout termination, all outputs registered.
module bus_master_68k #(
  parameter int TIMEOUT = 64
) (
  input logic              CLK,
  input logic              RST,
  bus_master_68k_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_TERM    = 3'd3;
  localparam logic [2:0] S_RECOVER = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dtack_s1_q, dtack_s1_d, dtack_s_q, dtack_s_d;
  logic          berr_s1_q, berr_s1_d, berr_s_q, berr_s_d;
  logic          st1_q, st1_d, st2_q, st2_d;
  logic          rw_lat_q, rw_lat_d;
  logic [1:0]    bs_q, bs_d;
  logic          as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d;
  logic          oe_q, oe_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [15:0]   rdata_q, rdata_d, dout_q, dout_d;
  logic [22:0]   addr_q, addr_d;

  assign bus.AS       = as_q;
  assign bus.UDS      = uds_q;
  assign bus.LDS      = lds_q;
  assign bus.RW       = rw_q;
  assign bus.DATA_OE  = oe_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
  assign bus.RDATA    = rdata_q;
  assign bus.ADDR_OUT = addr_q;
  assign bus.DATA_OUT = dout_q;

  // Next-state and next-output logic for the bus cycle FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dtack_s1_d = bus.DTACK;
    dtack_s_d  = dtack_s1_q;
    berr_s1_d  = bus.BERR;
    berr_s_d   = berr_s1_q;
    // Strobe-active flag delayed alongside the synchronizer: DTACK only counts
    // if it was sampled while the strobes were already on the bus.
    st1_d      = ~(uds_q & lds_q);
    st2_d      = st1_q;
    rw_lat_d   = rw_lat_q;
    bs_d       = bs_q;
    as_d       = as_q;
    uds_d      = uds_q;
    lds_d      = lds_q;
    rw_d       = rw_q;
    oe_d       = oe_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    dout_d     = dout_q;
    addr_d     = addr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          if (bus.BYTE_SEL == 2'b00) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = S_ADDR;
            addr_d   = bus.ADDR_IN;
            rw_lat_d = bus.RW_REQ;
            bs_d     = bus.BYTE_SEL;
            rw_d     = bus.RW_REQ;
            busy_d   = 1'b1;
            if (bus.RW_REQ) begin
              oe_d = 1'b0;
            end else begin
              dout_d = bus.WDATA;
              oe_d   = 1'b1;
            end
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ADDR: begin
        state_d = S_WAIT;
        as_d    = 1'b0;
        cnt_d   = '0;
        if (rw_lat_q) begin
          uds_d = ~bs_q[1];
          lds_d = ~bs_q[0];
        end else begin
          uds_d = 1'b1;
          lds_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (!berr_s_q || (cnt_q == TMO)) begin
          state_d = S_TERM;
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (!dtack_s_q && st2_q) begin
          state_d = S_TERM;
          as_d    = 1'b1;
          uds_d   = 1'b1;
          lds_d   = 1'b1;
          done_d  = 1'b1;
          if (rw_lat_q) begin
            rdata_d = bus.DATA_IN & {{8{bs_q[1]}}, {8{bs_q[0]}}};
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          uds_d = ~bs_q[1];
          lds_d = ~bs_q[0];
        end
      end

      S_TERM: begin
        state_d = S_RECOVER;
        oe_d    = 1'b0;
        rw_d    = 1'b1;
      end

      S_RECOVER: begin
        if (dtack_s_q && berr_s_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RECOVER;
        end
      end

      default: begin
        state_d = S_IDLE;
        as_d    = 1'b1;
        uds_d   = 1'b1;
        lds_d   = 1'b1;
        rw_d    = 1'b1;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, synchronizer and output registers; reset parks every strobe high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dtack_s1_q <= 1'b1;
      dtack_s_q  <= 1'b1;
      berr_s1_q  <= 1'b1;
      berr_s_q   <= 1'b1;
      st1_q      <= 1'b0;
      st2_q      <= 1'b0;
      rw_lat_q   <= 1'b1;
      bs_q       <= 2'b00;
      as_q       <= 1'b1;
      uds_q      <= 1'b1;
      lds_q      <= 1'b1;
      rw_q       <= 1'b1;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 16'h0000;
      dout_q     <= 16'h0000;
      addr_q     <= 23'h000000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dtack_s1_q <= dtack_s1_d;
      dtack_s_q  <= dtack_s_d;
      berr_s1_q  <= berr_s1_d;
      berr_s_q   <= berr_s_d;
      st1_q      <= st1_d;
      st2_q      <= st2_d;
      rw_lat_q   <= rw_lat_d;
      bs_q       <= bs_d;
      as_q       <= as_d;
      uds_q      <= uds_d;
      lds_q      <= lds_d;
      rw_q       <= rw_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      dout_q     <= dout_d;
      addr_q     <= addr_d;
    end
  end

endmodule

// File: tb/tb_bus_master_68k.sv
// Directed bench for bus_master_68k: reads, writes, invalid request, bus error,
// timeout, held DTACK in recovery and reset mid-cycle.
module tb_bus_master_68k;

  logic clk = 1'b0;
  logic rst;
  logic dtack_en, dtack_hold, berr_en;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bus_master_68k_if bus ();

  bus_master_68k #(.TIMEOUT(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Responder: DTACK/BERR follow AS combinationally when enabled.
  assign bus.DTACK = dtack_hold ? 1'b0 : (dtack_en ? bus.AS : 1'b1);
  assign bus.BERR  = berr_en ? bus.AS : 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic rw, input logic [22:0] a, input logic [1:0] bs,
                       input logic [15:0] wd);
    bus.REQ      = 1'b1;
    bus.RW_REQ   = rw;
    bus.ADDR_IN  = a;
    bus.BYTE_SEL = bs;
    bus.WDATA    = wd;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (bus.BUSY === 1'b0) break;
      tick(1);
    end
    chk(tag, bus.BUSY, 1'b0);
  endtask

  int   as_low;
  logic done_seen, err_seen;

  initial begin
    rst = 1'b1;
    dtack_en = 1'b0; dtack_hold = 1'b0; berr_en = 1'b0;
    bus.REQ = 1'b0; bus.RW_REQ = 1'b1; bus.ADDR_IN = 23'h0;
    bus.BYTE_SEL = 2'b00; bus.WDATA = 16'h0; bus.DATA_IN = 16'h0;
    tick(2);
    chk("rst_strobes", {bus.AS, bus.UDS, bus.LDS, bus.RW}, 4'hF);
    chk("rst_ctl", {bus.DATA_OE, bus.BUSY, bus.DONE, bus.ERR}, 4'h0);
    chk("rst_rdata", bus.RDATA, 16'h0000);
    chk("rst_addr", bus.ADDR_OUT, 23'h000000);
    chk("rst_dout", bus.DATA_OUT, 16'h0000);
    rst = 1'b0;
    tick(1);

    // Invalid request: no bus activity, DONE+ERR next cycle.
    start(1'b1, 23'h000001, 2'b00, 16'h0);
    tick(1); bus.REQ = 1'b0;
    chk("inv_done", {bus.DONE, bus.ERR, bus.BUSY, bus.AS}, 4'b1101);
    tick(1);
    chk("inv_pulse", bus.DONE, 1'b0);

    // Word read at 0x500000.
    dtack_en = 1'b1; bus.DATA_IN = 16'hBEEF;
    start(1'b1, 23'h280000, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    chk("rd_addr", {bus.AS, bus.BUSY, bus.RW, bus.DATA_OE}, 4'b1110);
    chk("rd_addr_out", bus.ADDR_OUT, 23'h280000);
    tick(1);
    chk("rd_wait", {bus.AS, bus.UDS, bus.LDS}, 3'b000);
    tick(2);
    chk("rd_early", bus.DONE, 1'b0);
    tick(1);
    chk("rd_done", {bus.DONE, bus.ERR}, 2'b10);
    chk("rd_data", bus.RDATA, 16'hBEEF);
    tick(1);
    chk("rd_pulse", {bus.DONE, bus.BUSY, bus.AS}, 3'b011);
    wait_idle("rd_idle");

    // Lower-byte write.
    bus.DATA_IN = 16'h7777;
    start(1'b0, 23'h012345, 2'b01, 16'h1234);
    tick(1); bus.REQ = 1'b0;
    chk("wr_addr", {bus.AS, bus.DATA_OE, bus.RW}, 3'b110);
    chk("wr_dout", bus.DATA_OUT, 16'h1234);
    tick(1);
    chk("wr_w1", {bus.AS, bus.UDS, bus.LDS}, 3'b011);
    tick(1);
    chk("wr_w2", {bus.AS, bus.UDS, bus.LDS}, 3'b010);
    tick(2);
    chk("wr_early", bus.DONE, 1'b0);
    tick(1);
    chk("wr_done", {bus.DONE, bus.ERR, bus.DATA_OE, bus.AS, bus.LDS}, 5'b10111);
    tick(1);
    chk("wr_rec", {bus.DATA_OE, bus.RW, bus.BUSY}, 3'b011);
    chk("wr_rdata", bus.RDATA, 16'hBEEF);
    wait_idle("wr_idle");

    // Upper-byte read: lower lane must read back as zero.
    bus.DATA_IN = 16'hA5C3;
    start(1'b1, 23'h7FFFFF, 2'b10, 16'h0);
    tick(1); bus.REQ = 1'b0;
    tick(1);
    chk("ub_strobe", {bus.UDS, bus.LDS}, 2'b01);
    tick(3);
    chk("ub_done", {bus.DONE, bus.ERR}, 2'b10);
    chk("ub_data", bus.RDATA, 16'hA500);
    wait_idle("ub_idle");

    // BERR and DTACK together: error wins, RDATA untouched.
    berr_en = 1'b1; bus.DATA_IN = 16'h5555;
    start(1'b1, 23'h000100, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    tick(4);
    chk("be_done", {bus.DONE, bus.ERR}, 2'b11);
    chk("be_rdata", bus.RDATA, 16'hA500);
    wait_idle("be_idle");
    berr_en = 1'b0;

    // Timeout with no DTACK; a second REQ mid-wait must be dropped.
    dtack_en = 1'b0;
    start(1'b1, 23'h0AAAAA, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    as_low = 0; done_seen = 1'b0; err_seen = 1'b0;
    for (int i = 0; i < 30 && !done_seen; i++) begin
      tick(1);
      if (i == 2) begin
        bus.REQ = 1'b1; bus.ADDR_IN = 23'h333333;
      end else begin
        bus.REQ = 1'b0;
      end
      if (bus.AS === 1'b0) as_low++;
      if (bus.DONE === 1'b1) begin
        done_seen = 1'b1; err_seen = bus.ERR;
      end
    end
    chk("to_as_low", as_low, 9);
    chk("to_done", {done_seen, err_seen}, 2'b11);
    wait_idle("to_idle");
    tick(3);
    chk("to_ignored_busy", bus.BUSY, 1'b0);
    chk("to_ignored_addr", bus.ADDR_OUT, 23'h0AAAAA);

    // DTACK held low after TERM keeps the block in recovery.
    dtack_en = 1'b1; bus.DATA_IN = 16'h0F0F;
    start(1'b1, 23'h000200, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    tick(4);
    chk("hd_done", bus.DONE, 1'b1);
    dtack_hold = 1'b1;
    tick(6);
    chk("hd_busy", {bus.BUSY, bus.DONE}, 2'b10);
    dtack_hold = 1'b0;
    tick(1);
    chk("hd_r1", bus.BUSY, 1'b1);
    tick(1);
    chk("hd_r2", bus.BUSY, 1'b1);
    tick(1);
    chk("hd_idle", bus.BUSY, 1'b0);

    // Reset mid-WAIT, then a request on the first edge after release.
    dtack_en = 1'b0;
    start(1'b1, 23'h000300, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    tick(2);
    chk("rs_wait", {bus.AS, bus.UDS, bus.LDS}, 3'b000);
    #2 rst = 1'b1;
    #1 chk("rs_async", {bus.AS, bus.UDS, bus.LDS, bus.BUSY, bus.DONE}, 5'b11100);
    tick(1);
    chk("rs_hold", {bus.AS, bus.BUSY, bus.DONE}, 3'b100);
    rst = 1'b0; dtack_en = 1'b1; bus.DATA_IN = 16'hCAFE;
    start(1'b1, 23'h000010, 2'b11, 16'h0);
    tick(1); bus.REQ = 1'b0;
    chk("rs_accept", {bus.BUSY, bus.DONE}, 2'b10);
    tick(3);
    chk("rs_early", bus.DONE, 1'b0);
    tick(1);
    chk("rs_done", {bus.DONE, bus.ERR}, 2'b10);
    chk("rs_data", bus.RDATA, 16'hCAFE);
    wait_idle("rs_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_master_68k.md
BUS_MASTER_68K -- requirements
Module: bus_master_68k

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: number of WAIT-state cycles without termination before the cycle is aborted.
REQ-002 SHALL have ports (name, direction, width, meaning):
- CLK, in, 1: system clock.
- RST, in, 1: asynchronous, active-high reset.
- REQ, in, 1: start cycle; sampled only in IDLE.
- RW_REQ, in, 1: 1 = read, 0 = write.
- ADDR_IN, in, 23: word address [23:1].
- BYTE_SEL, in, 2: [1] = upper byte, [0] = lower byte.
- WDATA, in, 16: write data.
- BUSY, out, 1: cycle in progress.
- DONE, out, 1: one-cycle completion pulse.
- ERR, out, 1: qualifies DONE (BERR, timeout or invalid request).
- RDATA, out, 16: captured read data.
- ADDR_OUT, out, 23: bus address [23:1].
- DATA_OUT, out, 16: bus write data.
- DATA_OE, out, 1: bus data driver enable.
- DATA_IN, in, 16: bus read data.
- AS, out, 1: address strobe, active-low.
- UDS, out, 1: upper data strobe, active-low.
- LDS, out, 1: lower data strobe, active-low.
- RW, out, 1: 1 = read.
- DTACK, in, 1: data acknowledge, active-low, asynchronous.
- BERR, in, 1: bus error, active-low, asynchronous.

Function
REQ-003 SHALL pass DTACK and BERR through two-flop synchronizers (DTACK_S, BERR_S) before any FSM use.
REQ-004 SHALL implement states IDLE, ADDR, WAIT, TERM, RECOVER; all bus outputs SHALL be registered.
REQ-005 IDLE: AS, UDS, LDS = 1; RW = 1; DATA_OE = 0; BUSY = 0; REQ = 1 SHALL latch ADDR_IN, RW_REQ, BYTE_SEL, WDATA and go to ADDR.
REQ-006 When REQ = 1 with BYTE_SEL = 00, the block SHALL produce no bus activity and SHALL pulse DONE = ERR = 1 on the next cycle, staying in IDLE.
REQ-007 ADDR (one cycle): the following SHALL hold, and the FSM SHALL then go to WAIT.
- ADDR_OUT and RW are valid.
- AS = 1.
- For writes, DATA_OUT = WDATA and DATA_OE = 1.
REQ-008 WAIT: AS = 0; strobe timing SHALL be as follows.
- Reads: UDS = ~BYTE_SEL[1] and LDS = ~BYTE_SEL[0] from the first WAIT cycle.
- Writes: the same strobes from the second WAIT cycle onward.
REQ-009 The timeout counter SHALL clear on WAIT entry and increment each WAIT cycle; its width is ceil(log2(TIMEOUT+1)).
REQ-010 WAIT exit priority SHALL be, highest first; every exit goes to TERM.
- BERR_S = 0: error.
- Counter = TIMEOUT: error.
- DTACK_S = 0 with strobes already asserted: success.
REQ-011 On a successful read exit, RDATA SHALL capture DATA_IN on the exiting edge; unselected byte lanes SHALL be zero; RDATA SHALL be unchanged on writes and errors.
REQ-012 TERM (one cycle): AS, UDS, LDS = 1; DONE = 1; ERR set per REQ-010; DATA_OE stays 1 for writes (hold time); then go to RECOVER.
REQ-013 RECOVER: DATA_OE = 0, RW = 1; the FSM SHALL stay until DTACK_S = 1 and BERR_S = 1, then go to IDLE.
REQ-014 BUSY SHALL be 1 in ADDR, WAIT, TERM and RECOVER.
REQ-015 REQ outside IDLE SHALL be ignored and not queued.
REQ-016 DONE SHALL be exactly one cycle wide per accepted REQ.
REQ-017 Latency: with the responder driving DTACK low combinationally from AS, and REQ sampled at edge E0:
- AS falls after E1.
- DONE is high in the cycle after E4 for reads and after E5 for writes.

Reset
REQ-018 RST = 1 SHALL asynchronously force the following, including mid-cycle with no glitch-low on any strobe:
- State IDLE.
- AS, UDS, LDS, RW = 1.
- DATA_OE, BUSY, DONE, ERR = 0.
- RDATA, ADDR_OUT, DATA_OUT = 0.
- Synchronizers = 1.
- Counter = 0.
REQ-019 After RST falls, the first REQ SHALL be accepted at the first CLK edge with RST low.

Verification
REQ-020 Word read: REQ, RW_REQ = 1, ADDR_IN = 0x500000 >> 1, BYTE_SEL = 11; responder DTACK = AS, DATA_IN = 0xBEEF. Required response:
- UDS = LDS = 0 with AS.
- DONE = 1 and ERR = 0 at E0+4.
- RDATA = 0xBEEF.
REQ-021 Lower-byte write: RW_REQ = 0, BYTE_SEL = 01, WDATA = 0x1234. Required response:
- DATA_OE = 1 one cycle before AS falls.
- LDS falls one cycle after AS; UDS stays 1.
- DONE at E0+5.
- DATA_OE drops in RECOVER.
REQ-022 BERR and DTACK driven low in the same cycle → DONE = ERR = 1 and RDATA unchanged.
REQ-023 DTACK never asserted, TIMEOUT = 8 → AS low for exactly 8 WAIT cycles + 1 and DONE = ERR = 1; a second REQ during the wait is ignored.
REQ-024 DTACK held low after TERM → the block stays in RECOVER with BUSY = 1 until DTACK rises, then IDLE after 2 synchronizer cycles.
REQ-025 RST pulsed mid-WAIT → AS, UDS, LDS return high asynchronously, no DONE pulse, and a new REQ completes normally.
